// File: rtl/conf_pkg.sv
// Shared definitions for the CONF receiver: default bus widths, the buffered
// entry layout, the default commit address and the error counter width.
package conf_pkg;

  localparam int CONF_ADDR_W      = 4;
  localparam int CONF_DATA_W      = 14;
  localparam int CONF_COMMIT_ADDR = 15;
  localparam int ERR_CNT_W        = 8;

  typedef struct packed {
    logic [CONF_ADDR_W-1:0] addr;
    logic [CONF_DATA_W-1:0] data;
  } conf_entry_t;

endpackage

// File: rtl/conf_fifo.sv
// Generic synchronous FIFO with a power-of-two depth. The head entry is read
// combinationally so a word pushed at one edge can be popped at the next.
module conf_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   level_reg;
  logic [PTR_W:0]   level_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (level_reg == (PTR_W+1)'(DEPTH));
  assign empty = (level_reg == '0);
  assign level = level_reg;
  assign dout  = mem[rd_ptr_reg];

  always_comb begin
    level_next = level_reg;
    if (do_push && !do_pop) begin
      level_next = level_reg + (PTR_W+1)'(1);
    end else if (do_pop && !do_push) begin
      level_next = level_reg - (PTR_W+1)'(1);
    end
  end

  // Storage is not reset; the pointers and level define which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg <= level_next;
    end
  end

endmodule

// File: rtl/conf_reg_bank.sv
// Configuration receiver: buffers CONF writes in a FIFO, drains them into a
// shadow bank and copies shadow to active on a commit (or writes active directly).
module conf_reg_bank
  import conf_pkg::*;
#(
  parameter int ADDR_W      = CONF_ADDR_W,
  parameter int DATA_W      = CONF_DATA_W,
  parameter int NUM_REGS    = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int COMMIT_ADDR = CONF_COMMIT_ADDR,
  parameter bit DIRECT      = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_W-1:0]               c_addr,
  input  logic [DATA_W-1:0]               c_data,
  input  logic                            c_valid,
  output logic                            c_ready,
  input  logic                            hold,
  output logic [NUM_REGS*DATA_W-1:0]      cfg_out,
  output logic                            cfg_update,
  output logic [ERR_CNT_W-1:0]            err_cnt,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [ADDR_W-1:0]  pop_addr;
  logic [DATA_W-1:0]  pop_data;
  logic               in_range;
  logic               is_commit;
  logic               cfg_update_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  assign c_ready = !rst && !fifo_full;
  assign push    = c_valid && c_ready;
  assign pop     = !fifo_empty && !hold;

  conf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({c_addr, c_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign pop_addr  = head[ENTRY_W-1 -: ADDR_W];
  assign pop_data  = head[DATA_W-1:0];
  assign in_range  = (pop_addr < ADDR_W'(NUM_REGS));
  // In direct mode the commit address is just another out-of-range write.
  assign is_commit = !DIRECT && (pop_addr == ADDR_W'(COMMIT_ADDR));

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] shadow_reg;
      logic [DATA_W-1:0] active_reg;
      logic              hit;

      assign hit = pop && (pop_addr == ADDR_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg <= '0;
          active_reg <= '0;
        end else if (DIRECT) begin
          if (hit) active_reg <= pop_data;
        end else begin
          if (hit) shadow_reg <= pop_data;
          if (pop && is_commit) active_reg <= shadow_reg;
        end
      end

      assign cfg_out[gi*DATA_W +: DATA_W] = active_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_update_reg <= 1'b0;
      err_cnt_reg    <= '0;
    end else begin
      cfg_update_reg <= pop && (DIRECT ? in_range : is_commit);
      if (pop && !in_range && !is_commit && (err_cnt_reg != '1)) begin
        err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
      end
    end
  end

  assign cfg_update = cfg_update_reg;
  assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_conf_reg_bank.sv
// Bench for conf_reg_bank: directed and random CONF traffic against a queue-based
// reference model, checking all outputs after every clock edge.
module tb_conf_reg_bank;
  import conf_pkg::*;

  localparam int NR    = 12;
  localparam int DW    = CONF_DATA_W;
  localparam int AW    = CONF_ADDR_W;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CW    = NR * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_data = '0;
  logic          c_valid = 1'b0;
  logic          hold = 1'b0;

  logic          c_ready, cfg_update, c_ready_d, cfg_update_d;
  logic [CW-1:0] cfg_out, cfg_out_d;
  logic [7:0]    err_cnt, err_cnt_d;
  logic [LW-1:0] fifo_level, fifo_level_d;

  always #5 clk = ~clk;

  conf_reg_bank #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .FIFO_DEPTH(DEPTH),
    .COMMIT_ADDR(15), .DIRECT(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid),
    .c_ready(c_ready), .hold(hold), .cfg_out(cfg_out), .cfg_update(cfg_update),
    .err_cnt(err_cnt), .fifo_level(fifo_level)
  );

  conf_reg_bank #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .FIFO_DEPTH(DEPTH),
    .COMMIT_ADDR(15), .DIRECT(1'b1)
  ) dut_d (
    .clk(clk), .rst(rst), .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid),
    .c_ready(c_ready_d), .hold(hold), .cfg_out(cfg_out_d), .cfg_update(cfg_update_d),
    .err_cnt(err_cnt_d), .fifo_level(fifo_level_d)
  );

  int n_vec = 0;
  int n_err = 0;
  bit direct_mode = 1'b0;

  // Reference model: buffered writes as a queue, registers as plain arrays.
  conf_entry_t   q[$];
  logic [DW-1:0] shadow[NR];
  logic [DW-1:0] active[NR];
  int            err_m;
  bit            upd_m;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NR; i++) begin
      shadow[i] = '0;
      active[i] = '0;
    end
    err_m = 0;
    upd_m = 1'b0;
  endtask

  task automatic apply(input conf_entry_t e);
    int a;
    a = int'(e.addr);
    if (a < NR) begin
      if (direct_mode) begin
        active[a] = e.data;
        upd_m = 1'b1;
      end else begin
        shadow[a] = e.data;
      end
    end else if (!direct_mode && a == 15) begin
      active = shadow;
      upd_m = 1'b1;
    end else if (err_m < 255) begin
      err_m++;
    end
  endtask

  task automatic check_all();
    logic [CW-1:0] exp_cfg;
    for (int i = 0; i < NR; i++) exp_cfg[i*DW +: DW] = active[i];
    chk("cfg_out",    direct_mode ? cfg_out_d : cfg_out, exp_cfg);
    chk("cfg_update", CW'(direct_mode ? cfg_update_d : cfg_update), CW'(upd_m));
    chk("err_cnt",    CW'(direct_mode ? err_cnt_d : err_cnt), CW'(err_m));
    chk("fifo_level", CW'(direct_mode ? fifo_level_d : fifo_level), CW'(q.size()));
    chk("c_ready",    CW'(direct_mode ? c_ready_d : c_ready),
        CW'(!rst && (q.size() != DEPTH)));
  endtask

  task automatic tick();
    bit          do_push;
    bit          do_pop;
    conf_entry_t e;
    do_push = !rst && c_valid && (q.size() != DEPTH);
    do_pop  = !rst && (q.size() != 0) && !hold;
    e.addr  = c_addr;
    e.data  = c_data;
    @(posedge clk);
    upd_m = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (do_pop) apply(q.pop_front());
      if (do_push) begin
        q.push_back(e);
        $display("xfer mode=%0d addr=%0d data=%h level=%0d", direct_mode, e.addr, e.data, q.size());
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    c_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    acc = 1'b0;
    c_addr  = a;
    c_data  = d;
    c_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      acc = (q.size() != DEPTH);
      tick();
    end
    c_valid = 1'b0;
    n_vec++;
    assert (acc) else begin
      n_err++;
      $error("FAIL accept_timeout observed=not_accepted expected=accepted addr=%0d", a);
    end
  endtask

  task automatic rand_phase(input int n);
    for (int k = 0; k < n; k++) begin
      c_valid = 1'($urandom_range(0, 1));
      c_addr  = AW'($urandom_range(0, 15));
      c_data  = DW'($urandom);
      hold    = ($urandom_range(0, 3) == 0);
      tick();
    end
    hold = 1'b0;
    idle(DEPTH + 2);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Write then commit; cfg_out must stay zero until the commit pops.
    wr(4'd3, 14'h1A5);
    idle(3);
    wr(4'd15, 14'h0);
    idle(3);

    // Fill under hold, then release and push the blocked writes.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) wr(AW'(i + 4), DW'($urandom));
    c_addr = 4'd8; c_data = 14'h2222; c_valid = 1'b1;
    repeat (3) tick();
    hold = 1'b0;
    wr(4'd8, 14'h2222);
    wr(4'd9, 14'h3333);
    idle(8);
    wr(4'd15, 14'h0);
    idle(3);

    // Out-of-range writes, then saturation of the error counter.
    wr(4'd12, 14'h1);
    wr(4'd13, 14'h2);
    wr(4'd14, 14'h3);
    idle(3);
    for (int i = 0; i < 300; i++) wr(AW'($urandom_range(12, 14)), DW'($urandom));
    idle(3);

    // Back-to-back writes with repeated addresses, then commit.
    for (int i = 0; i < 20; i++) wr((i % 2) ? 4'd2 : 4'd7, DW'($urandom));
    wr(4'd15, 14'h0);
    idle(3);

    // Reset with buffered entries and modified shadow contents.
    wr(4'd5, 14'h0123);
    idle(2);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) wr(AW'(i), DW'($urandom));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold = 1'b0;
    wr(4'd15, 14'h0);
    idle(3);

    rand_phase(400);

    // Direct mode instance.
    direct_mode = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr(4'd0, 14'h3FFF);
    idle(3);
    wr(4'd15, 14'h5);
    idle(3);
    rand_phase(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conf_reg_bank.md
Name: conf_reg_bank

Overview:
- Parametrised configuration receiver; successor to the fixed 4-bit-address / 14-bit-data CONF port.
- Accepts CONF writes over a c_valid/c_ready handshake and buffers them in a small FIFO.
- Drains entries into a shadow register array; a commit address atomically copies shadow to active, or direct mode writes active registers immediately.
- Sits between the CONF master and the datapath blocks that consume cfg_out.

Parameters:
- ADDR_W, 4: c_addr width.
- DATA_W, 14: c_data and per-register width.
- NUM_REGS, 12: number of config registers; must be < COMMIT_ADDR.
- FIFO_DEPTH, 4: input buffer entries; power of 2, >= 2.
- COMMIT_ADDR, 15: address that triggers shadow-to-active copy; must be <= 2**ADDR_W-1.
- DIRECT, 0: 1 means writes go straight to the active registers and COMMIT_ADDR is treated as out-of-range.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- c_addr  in  ADDR_W  write address.
- c_data  in  DATA_W  write data.
- c_valid  in  1  write request.
- c_ready  out  1  block can accept a write this cycle.
- hold  in  1  1 pauses FIFO drain; acceptance continues until full.
- cfg_out  out  NUM_REGS*DATA_W  active registers; reg i at bits [i*DATA_W +: DATA_W].
- cfg_update  out  1  one-cycle pulse after the active registers change.
- err_cnt  out  8  saturating count of out-of-range writes.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst high at posedge): FIFO empty; shadow, active, cfg_update and err_cnt all 0; c_ready 0 while rst high.
- Reset mid-operation discards buffered entries and uncommitted shadow contents.
- Handshake:
  - c_ready = !rst && (fifo_level != FIFO_DEPTH), combinational from registered state.
  - Transfer occurs at posedge when c_valid && c_ready.
  - c_valid without c_ready: nothing happens; the master holds its data.
- FIFO:
  - Push on transfer, pop when !empty && !hold, one pop per cycle.
  - Simultaneous push and pop leaves the level unchanged.
  - Push when full cannot occur because c_ready is 0.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order is strictly preserved.
- Pop processing, at the same posedge as the pop:
  - addr < NUM_REGS: shadow[addr] <= data (DIRECT=0) or active[addr] <= data (DIRECT=1).
  - addr == COMMIT_ADDR && DIRECT=0: active <= shadow for all regs; data is ignored; shadow is retained.
  - Otherwise: entry discarded; err_cnt increments, saturating at 255.
- Latency:
  - Write transferred at edge E0 into an empty FIFO with hold=0 is popped at E1.
  - The active/shadow update is visible after E1.
  - cfg_update is high for exactly the cycle following E1 (aligned with new cfg_out).
- cfg_update:
  - Fires on every commit (DIRECT=0) or every in-range write (DIRECT=1).
  - Fires even if the values are unchanged.
  - Back-to-back commits give consecutive high cycles.
- hold: when asserted the FIFO fills; c_ready drops after FIFO_DEPTH transfers. Releasing hold resumes drain the next cycle.
- Ordering: a write followed by a commit in the FIFO is processed in order, so the commit includes the write.
- No handshake deadlock: c_ready always recovers once hold=0.

Decomposition:
- conf_pkg holds:
  - default CONF_ADDR_W=4, CONF_DATA_W=14;
  - conf_entry_t struct {addr, data} parametrised through the package defaults;
  - CONF_COMMIT_ADDR constant;
  - err counter width ERR_CNT_W=8.
- Sub-module conf_fifo:
  - generic synchronous FIFO with push/pop/full/empty/level;
  - parameters WIDTH and DEPTH;
  - same clk/rst conventions.
- conf_reg_bank instantiates conf_fifo and contains the shadow/active arrays and the decode logic.

Test Plan:
- Reset then write addr 3 = 14'h1A5, then commit (addr 15), hold=0:
  - after the commit pop, cfg_out reg3 = 14'h1A5 and the others 0;
  - cfg_update is one pulse;
  - before the commit, cfg_out stays all 0.
- hold=1, issue 6 writes with FIFO_DEPTH=4:
  - c_ready drops after the 4th transfer and fifo_level=4;
  - release hold: entries drain in order, c_ready rises the cycle after the first pop;
  - writes 5 and 6 are accepted afterwards with no loss.
- Writes to addr 12, 13 and 14:
  - err_cnt=3, cfg_out unchanged, no cfg_update;
  - 300 such writes give err_cnt saturated at 255.
- DIRECT=1, write addr 0 = 14'h3FFF:
  - cfg_out reg0 updates and cfg_update pulses one cycle after the pop;
  - a write to addr 15 increments err_cnt.
- Continuous c_valid every cycle with hold=0:
  - c_ready stays 1 and fifo_level stays <= 1;
  - last-write-wins on a repeated address before the commit.
- rst asserted while the FIFO holds 3 entries and shadow is modified:
  - next cycle fifo_level=0, cfg_out=0, err_cnt=0;
  - a subsequent commit yields all-zero cfg_out.
